// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_DEPTH_DEF = 4;
    localparam int FETCH_XLEN_DEF  = 32;

    typedef struct packed {
        logic [FETCH_XLEN_DEF-1:0] pc;
        logic [FETCH_XLEN_DEF-1:0] instr;
    } fetch_entry_t;

    // Outstanding/drop counters must hold 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for the fetch buffer and the pc-tag queue.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_pop;

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign count  = cnt_q;
    assign dout   = mem_q[rd_q];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (push)
                wr_q <= wr_q + AW'(1);
            if (do_pop)
                rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the PC counter, issues imem requests, buffers {pc, instr}.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEF,
    parameter int XLEN  = FETCH_XLEN_DEF
) (
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_count,
    output logic [31:0]     perf_drop_count,
`endif
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_target,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);
    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0]     n_q, n_d, d_q, d_d;
    logic [CW-1:0]     buf_count, tag_count;
    logic              buf_full, buf_empty, tag_full, tag_empty;
    logic [XLEN-1:0]   tag_head;
    logic [2*XLEN-1:0] buf_head;
    logic              credit_ok, fire, rsp_live, rsp_drop, if_pop;

    // Credit covers both in-flight responses and occupied buffer slots.
    assign credit_ok      = ({1'b0, n_q} + {1'b0, buf_count}) < (CW + 1)'(DEPTH);
    assign imem_req_valid = !rst && !redir_valid && credit_ok;
    assign imem_req_addr  = pc_in;
    assign fire           = imem_req_valid && imem_req_ready;

    assign pc_en     = !rst && (redir_valid || fire);
    assign pc_load   = !rst && redir_valid;
    assign pc_target = redir_target;

    assign rsp_live = imem_rsp_valid && (d_q == '0);
    assign rsp_drop = imem_rsp_valid && (d_q != '0);

    assign if_valid           = !rst && !buf_empty;
    assign if_pop             = if_valid && if_ready;
    assign {if_pc, if_instr}  = buf_head;

    always_comb begin
        n_d = n_q + CW'(fire) - CW'(imem_rsp_valid);
        d_d = d_q;
        if (redir_valid)
            d_d = n_d;
        else if (rsp_drop)
            d_d = d_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q <= '0;
            d_q <= '0;
        end else begin
            assert (tag_count == n_q - d_q);
            assert (!rsp_live || !tag_empty);
            assert (!buf_full || n_q == '0);
            assert (!tag_full || buf_empty);
            n_q <= n_d;
            d_q <= d_d;
        end
    end

    fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_live),
        .pop   (if_pop),
        .flush (redir_valid),
        .din   ({tag_head, imem_rsp_data}),
        .dout  (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .pop   (rsp_live),
        .flush (redir_valid),
        .din   (pc_in),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, flush_q, drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            drop_q  <= '0;
        end else begin
            if (!imem_req_valid)
                stall_q <= stall_q + 32'd1;
            if (redir_valid)
                flush_q <= flush_q + 32'd1;
            if (rsp_drop)
                drop_q <= drop_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flush_count  = flush_q;
    assign perf_drop_count   = drop_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC counter and latency-configurable memory models plus a {pc, instr} scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_in;
    logic            pc_en, pc_load;
    logic [XLEN-1:0] pc_target;
    logic            redir_valid;
    logic [XLEN-1:0] redir_target;
    logic            imem_req_valid, imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid, if_ready;
    logic [XLEN-1:0] if_pc, if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_stall_cycles, perf_flush_count, perf_drop_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
`ifdef FETCH_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count),
        .perf_drop_count   (perf_drop_count),
`endif
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_en          (pc_en),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        bit          redir;
        logic [31:0] tgt;
        bit          ready;
        bit          e_req;
        bit          e_en;
        bit          e_load;
    } vec_t;

    int           total = 0;
    int           bad   = 0;
    mreq_t        memq[$];
    fetch_entry_t expq[$];
    logic [31:0]  poplog[$];
    int           cyc = 0;
    int           lat = 1;
    bit           mem_on = 1'b1;
    bit           cur_stale = 1'b0;
    int           drops = 0, stalls = 0, flushes = 0;

    bit           s_req_valid, s_fire, s_pc_en, s_pc_load, s_redir, s_pop;
    logic [31:0]  s_target, s_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle: sample at negedge, update models after posedge, drive next cycle's inputs.
    task automatic step();
        fetch_entry_t e;
        mreq_t        m;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_fire      = imem_req_valid && imem_req_ready;
        s_pc_en     = pc_en;
        s_pc_load   = pc_load;
        s_target    = pc_target;
        s_addr      = imem_req_addr;
        s_redir     = redir_valid;
        s_pop       = if_valid && if_ready;
        if (!rst) begin
            if (!s_req_valid) stalls++;
            if (imem_rsp_valid && cur_stale) drops++;
            if (s_redir) begin
                flushes++;
                foreach (memq[i]) memq[i].stale = 1'b1;
                expq.delete();
            end else if (s_pop) begin
                poplog.push_back(if_pc);
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_pop: got pc %h want no entry", if_pc);
                end else begin
                    e = expq.pop_front();
                    chk("pop_pc", if_pc, e.pc);
                    chk("pop_instr", if_instr, e.instr);
                end
            end
            if (s_fire) begin
                chk("req_addr", s_addr, pc_in);
                memq.push_back('{addr: pc_in, due: cyc + lat, stale: 1'b0});
                expq.push_back('{pc: pc_in, instr: mem_word(pc_in)});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) pc_in = '0;
        else if (s_pc_en) pc_in = s_pc_load ? s_target : pc_in + 32'd1;
        imem_rsp_valid = 1'b0;
        if (mem_on && memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(m.addr);
            cur_stale      = m.stale;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redir_valid = 1'b0;
        repeat (2) step();
        memq.delete();
        expq.delete();
        poplog.delete();
        imem_rsp_valid = 1'b0;
        cur_stale = 1'b0;
        pc_in = '0;
        rst = 1'b0;
        drops = 0;
        stalls = 0;
        flushes = 0;
    endtask

    task automatic wait_pop(input string name, input int maxc);
        int n;
        n = 0;
        while (poplog.size() == 0 && n < maxc) begin
            step();
            n++;
        end
        if (poplog.size() == 0) fail_now(name);
    endtask

    vec_t vt[9];

    initial begin
        int cnt;
        vt[0] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0};
        vt[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0};
        vt[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        pc_in = '0;
        redir_valid = 1'b1;
        redir_target = 32'h55;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        if_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        do_reset();

        // Priority and credit table; memory silent so outstanding count only grows.
        mem_on = 1'b0;
        for (int i = 0; i < 9; i++) begin
            redir_valid    = vt[i].redir;
            redir_target   = vt[i].tgt;
            imem_req_ready = vt[i].ready;
            step();
            chk($sformatf("vec%0d_req", i), s_req_valid, vt[i].e_req);
            chk($sformatf("vec%0d_en", i), s_pc_en, vt[i].e_en);
            chk($sformatf("vec%0d_load", i), s_pc_load, vt[i].e_load);
            if (vt[i].e_load) chk($sformatf("vec%0d_tgt", i), s_target, vt[i].tgt);
        end
        redir_valid = 1'b0;
        mem_on = 1'b1;
        do_reset();

        // Streaming, 1-cycle memory.
        lat = 1;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (s_pc_en) cnt++;
        end
        chk("stream_pc_en", cnt, 24);
        chk("stream_pops", poplog.size(), 22);
        for (int k = 0; k < 8; k++) chk($sformatf("stream_pc%0d", k), poplog[k], k);
        do_reset();

        // Decode stalled: exactly DEPTH requests, then drain in order.
        if_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_fire) cnt++;
        end
        chk("bp_fires", cnt, 4);
        chk("bp_req_valid", s_req_valid, 0);
        chk("bp_pc_en", s_pc_en, 0);
        chk("bp_pc_hold", pc_in, 4);
        if_ready = 1'b1;
        repeat (6) step();
        chk("bp_drain_n", poplog.size() >= 4, 1);
        for (int k = 0; k < 4; k++) chk($sformatf("bp_drain%0d", k), poplog[k], k);
        do_reset();

        // Latency 3, redirect at PC 6.
        lat = 3;
        cnt = 0;
        while (pc_in != 32'd6 && cnt < 50) begin
            step();
            cnt++;
        end
        if (pc_in != 32'd6) fail_now("lat3_reach_pc6");
        redir_valid = 1'b1;
        redir_target = 32'h100;
        step();
        redir_valid = 1'b0;
        chk("lat3_load", s_pc_load, 1);
        chk("lat3_en", s_pc_en, 1);
        chk("lat3_tgt", s_target, 32'h100);
        chk("lat3_req_blocked", s_req_valid, 0);
        poplog.delete();
        wait_pop("lat3_first_pop", 40);
        if (poplog.size() > 0) chk("lat3_first_pc", poplog[0], 32'h100);
        do_reset();

        // Redirect coinciding with a live response and a decode pop.
        lat = 2;
        cnt = 0;
        while (!(imem_rsp_valid && !cur_stale && if_valid) && cnt < 30) begin
            step();
            cnt++;
        end
        if (!(imem_rsp_valid && !cur_stale && if_valid)) fail_now("coinc_setup");
        redir_valid = 1'b1;
        redir_target = 32'h200;
        step();
        redir_valid = 1'b0;
        chk("coinc_flushed", if_valid, 0);
        poplog.delete();
        wait_pop("coinc_first_pop", 40);
        if (poplog.size() > 0) chk("coinc_first_pc", poplog[0], 32'h200);
        do_reset();

        // Reset mid-stream: outputs drop at once, restart from PC 0.
        lat = 2;
        repeat (6) step();
        redir_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_pc_en", pc_en, 0);
        chk("mid_rst_pc_load", pc_load, 0);
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_if_valid", if_valid, 0);
        do_reset();
        wait_pop("mid_rst_restart", 20);
        if (poplog.size() > 0) chk("mid_rst_first_pc", poplog[0], 0);

`ifdef FETCH_PERF_EN
        do_reset();
        lat = 3;
        if_ready = 1'b0;
        repeat (8) step();
        redir_valid = 1'b1;
        redir_target = 32'h300;
        step();
        redir_valid = 1'b0;
        repeat (2) step();
        redir_valid = 1'b1;
        redir_target = 32'h400;
        step();
        redir_valid = 1'b0;
        if_ready = 1'b1;
        repeat (10) step();
        chk("perf_flush", perf_flush_count, 2);
        chk("perf_flush_model", perf_flush_count, flushes);
        chk("perf_drop", perf_drop_count, drops);
        chk("perf_stall", perf_stall_cycles, stalls);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits on the consumer side of the program counter.
- Reads the PC value and drives the counter's enable, load and load-value inputs, so the counter advances only when an instruction-memory request is accepted and reloads on a redirect.
- Issues word-addressed requests to instruction memory and buffers the in-order responses as {pc, instr} pairs for decode.
- Discards stale responses after a branch/jump redirect.

Parameters:
- DEPTH, 4: fetch buffer entries; also the cap on (outstanding requests + buffered entries). Power of two, 2..16.
- XLEN, 32: PC and instruction width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- pc_in  input  XLEN  current PC value from the program counter
- pc_en  output  1  counter enable
- pc_load  output  1  counter load select (load pc_target instead of +1)
- pc_target  output  XLEN  counter load value
- redir_valid  input  1  redirect request from execute stage
- redir_target  input  XLEN  redirect PC
- imem_req_valid  output  1  memory request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  word address (= pc_in)
- imem_rsp_valid  input  1  response valid; responses return in request order; no backpressure
- imem_rsp_data  input  XLEN  instruction word
- if_valid  output  1  buffer head valid to decode
- if_ready  input  1  decode accepts head
- if_pc  output  XLEN  PC of head instruction
- if_instr  output  XLEN  head instruction

Behaviour:
- Reset: all state is cleared. N (outstanding count) = 0, D (drop count) = 0, buffer empty, pc-tag queue empty.
- While rst is high, pc_en, pc_load, imem_req_valid and if_valid are all 0.
- Issue condition: imem_req_valid = !redir_valid && (N + count < DEPTH).
- imem_req_addr = pc_in.
- A request fires when imem_req_valid && imem_req_ready. On fire:
  - pc_en = 1 and pc_load = 0, so the counter holds pc_in+1 next cycle.
  - pc_in is pushed into the pc-tag queue.
  - N increments.
- Redirect (redir_valid = 1):
  - pc_en = 1, pc_load = 1, pc_target = redir_target, all combinational, same cycle.
  - Redirect has priority over increment; no request is issued that cycle.
  - On the clock edge: the buffer and pc-tag queue are flushed, any if_ready pop is ignored, and D takes the value N_next, so every still-outstanding response is marked stale.
- When neither fire nor redirect occurs: pc_en = 0, pc_load = 0 and the counter holds.
- Response handling (imem_rsp_valid):
  - N decrements.
  - If D > 0: data is discarded, D decrements, and nothing is pushed.
  - Otherwise: {pc-tag head, imem_rsp_data} is pushed to the buffer and the tag is popped.
- The credit rule guarantees a buffer slot always exists for every response; buffer overflow is illegal and must be asserted in simulation.
- Decode side:
  - if_valid = buffer not empty; if_pc/if_instr = head entry.
  - A pop happens on if_valid && if_ready.
  - Push and pop in the same cycle keeps count unchanged.
  - With the buffer full and no pop, issue stops via the credit rule.
- Simultaneous response and redirect in one cycle: the response is processed under the old D; it is pushed if live, then flushed by the redirect. Net result: buffer empty, D = N - 1.
- Back-to-back redirects: each one recomputes D = N_next; the last target wins.
- Counter width: N and D are clog2(DEPTH)+1 bits; the sum N + count never exceeds DEPTH.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cycles [31:0] (cycles with !imem_req_valid and rst low), perf_flush_count [31:0] (redirect cycles) and perf_drop_count [31:0] (discarded responses).
  - All three reset to 0 and wrap at 2^32.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - a localparam for the default DEPTH;
  - the fetch-entry struct/typedef {pc[XLEN-1:0], instr[XLEN-1:0]};
  - the width function for the N/D counters.
- One sub-module, fetch_fifo: a synchronous FIFO with parameters WIDTH/DEPTH, ports push, pop, flush, full, empty and count.
  - Instantiated twice: as the fetch buffer (2*XLEN wide) and as the pc-tag queue (XLEN wide).
- Top-level RTL holds the N/D counters and the pc/imem/redirect glue.

Test Plan:
- Reset then stream with memory always ready, 1-cycle response, if_ready = 1 -> pc_en pulses every cycle; if_pc = 0,1,2,3...; if_instr matches memory content at each.
- if_ready = 0 with DEPTH = 4 -> exactly 4 requests are issued, then imem_req_valid = 0 and pc_en = 0 with pc_in holding at 4; releasing if_ready drains PCs 0..3 in order.
- Memory latency 3 and redir_valid for one cycle at PC 6 with target 0x100 and N = 3 -> same cycle pc_load = 1 and pc_target = 0x100; the next 3 responses are dropped; the first if_pc after that is 0x100.
- Redirect in the same cycle as a live response and an if_ready pop -> buffer empty afterwards, D = N - 1, and no stale PC ever reaches if_valid.
- rst asserted mid-stream with N = 2 -> outputs go to 0 immediately; after release, late responses must not be driven (bench drops them) and fetch restarts from PC 0.
- With FETCH_PERF_EN, 2 redirects, 5 dropped responses and 7 credit-stall cycles -> perf_flush_count = 2, perf_drop_count = 5, perf_stall_cycles = 7.
